// File: rtl/uart_transmitter.sv
// UART transmit engine: configurable data width, parity and stop bits, fed by a small input FIFO.
// Define UATX_BREAK_EN to add the SendBreak input (hold the line low while idle).
module uart_transmitter #(
  parameter int ClockFreq  = 50_000_000,
  parameter int BaudRate   = 115_200,
  parameter int DataBits   = 8,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1,
  parameter int FifoDepth  = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [DataBits-1:0]          DataIn,
  input  logic                         DataInValid,
`ifdef UATX_BREAK_EN
  input  logic                         SendBreak,
`endif
  output logic                         DataInReady,
  output logic                         SOut,
  output logic                         Busy,
  output logic [$clog2(FifoDepth):0]   FifoCount
);
  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SymW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam int PtrW = $clog2(FifoDepth);
  localparam int BitW = $clog2(DataBits);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DataBits-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]     r_wptr, r_rptr;
  logic [PtrW:0]       r_count;

  state_t              r_state;
  logic [SymW-1:0]     r_sym;
  logic [BitW-1:0]     r_bit;
  logic                r_stop;
  logic [DataBits-1:0] r_shift;
  logic                r_par;
  logic                r_sout;

  logic                w_push, w_pop, w_hold, w_sym_last, w_stop_last, w_par;
  logic [DataBits-1:0] w_head;

  assign DataInReady = (r_count != (PtrW+1)'(FifoDepth));
  assign w_push      = DataInValid && DataInReady;
  assign w_head      = r_mem[r_rptr];
  assign w_par       = (^w_head) ^ (ParityMode == 2);
  assign w_sym_last  = (r_sym == SymW'(SymbolEdgeTime - 1));
  assign w_stop_last = w_sym_last && (r_stop == 1'(StopBits - 1));

`ifdef UATX_BREAK_EN
  // r_guard keeps the line high for one full symbol after a break ends.
  logic r_guard;
  assign w_hold = SendBreak || r_guard;
`else
  assign w_hold = 1'b0;
`endif

  assign w_pop = (r_count != '0) && !w_hold &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_last));

  assign SOut      = r_sout;
  assign Busy      = (r_state != S_IDLE) || (r_count != '0);
  assign FifoCount = r_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= DataIn;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_sym   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_sout  <= 1'b1;
`ifdef UATX_BREAK_EN
      r_guard <= 1'b0;
`endif
    end else begin
      // Every state change lands on a symbol boundary, so this also clears on entry.
      r_sym <= w_sym_last ? '0 : r_sym + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_sym  <= '0;
          r_sout <= 1'b1;
`ifdef UATX_BREAK_EN
          if (SendBreak) begin
            r_sout  <= 1'b0;
            r_guard <= 1'b1;
          end else if (r_guard) begin
            r_sym <= r_sym + 1'b1;
            if (w_sym_last) begin
              r_guard <= 1'b0;
              r_sym   <= '0;
            end
          end
`endif
          if (w_pop) begin
            r_state <= S_START;
            r_shift <= w_head;
            r_par   <= w_par;
            r_bit   <= '0;
            r_sout  <= 1'b0;
          end
        end
        S_START: if (w_sym_last) begin
          r_state <= S_DATA;
          r_sout  <= r_shift[0];
        end
        S_DATA: if (w_sym_last) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
          if (r_bit == BitW'(DataBits - 1)) begin
            if (ParityMode != 0) begin
              r_state <= S_PARITY;
              r_sout  <= r_par;
            end else begin
              r_state <= S_STOP;
              r_sout  <= 1'b1;
              r_stop  <= 1'b0;
            end
          end else begin
            r_sout <= r_shift[1];
          end
        end
        S_PARITY: if (w_sym_last) begin
          r_state <= S_STOP;
          r_sout  <= 1'b1;
          r_stop  <= 1'b0;
        end
        S_STOP: if (w_sym_last) begin
          if (w_stop_last) begin
            if (w_pop) begin
              r_state <= S_START;
              r_shift <= w_head;
              r_par   <= w_par;
              r_bit   <= '0;
              r_sout  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_sout  <= 1'b1;
            end
          end else begin
            r_stop <= r_stop + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sout  <= 1'b1;
        end
      endcase
    end
  end
endmodule
